dma_stream_engine: RTL

DMA-side endpoint for the convolution input/output buffer interface. The transmit half reads `len` words from a synchronous source memory and streams them to the buffer's write port as a bubble-free valid/ready/last burst, then pulses `w_done`. The receive half sinks the buffer's read-back stream into a destination memory port. It sits between the system memory mover and the ping-pong ifmap/result buffer.

---
 rtl/dma_stream_engine.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/dma_stream_engine.sv
// DMA stream endpoint: TX reads a source memory into a bubble-free valid/ready/last burst,
// RX sinks a read-back stream into a destination memory. Optional macro: DMA_RX_LEN_CHECK_EN.
module dma_stream_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_SIZE  = 16,
  parameter int LEN_SIZE   = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  tx_start,
  input  logic [LEN_SIZE-1:0]   tx_len,
  input  logic [ADDR_SIZE-1:0]  src_base,
  output logic                  src_en,
  output logic [ADDR_SIZE-1:0]  src_addr,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_valid,
  output logic                  w_last,
  input  logic                  w_ready,
  output logic                  w_done,
  input  logic                  rx_start,
  input  logic [LEN_SIZE-1:0]   rx_len,
  input  logic [ADDR_SIZE-1:0]  dst_base,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic                  r_valid,
  input  logic                  r_last,
  output logic                  r_ready,
  output logic                  dst_we,
  output logic [ADDR_SIZE-1:0]  dst_addr,
  output logic [DATA_WIDTH-1:0] dst_data,
  output logic                  tx_busy,
  output logic                  rx_busy,
  output logic                  rx_done,
  output logic                  rx_err
);

  typedef enum logic [1:0] {TX_IDLE, TX_PRIME, TX_STREAM, TX_DONE} tx_state_t;
  typedef enum logic {RX_IDLE, RX_ACTIVE} rx_state_t;

  // ---------------- TX channel ----------------
  tx_state_t tx_state, tx_state_nx;

  logic [LEN_SIZE-1:0]   len_q, fetch_cnt, pop_cnt;
  logic [ADDR_SIZE-1:0]  base_q;
  logic [DATA_WIDTH-1:0] fifo_mem [0:1];
  logic                  rd_ptr, wr_ptr, inflight;
  logic [1:0]            fifo_cnt;
  logic [2:0]            level;
  logic                  tx_active, tx_accept, fetch, push, pop, last_beat;

  assign tx_active = (tx_state == TX_PRIME) || (tx_state == TX_STREAM);
  assign tx_accept = (tx_state == TX_IDLE) && tx_start;
  assign push      = inflight;
  assign w_valid   = tx_active && (fifo_cnt != 2'd0);
  assign pop       = w_valid && w_ready;
  assign last_beat = (pop_cnt == len_q - LEN_SIZE'(1));
  assign level     = {1'b0, fifo_cnt} + {2'b0, inflight};
  // occupancy + in-flight - pop < 2, written without a signed subtraction
  assign fetch     = tx_active && (fetch_cnt < len_q) &&
                     ((level < 3'd2) || (pop && (level == 3'd2)));

  assign src_en   = fetch;
  assign src_addr = fetch ? base_q + ADDR_SIZE'(fetch_cnt) : '0;
  assign w_data   = w_valid ? fifo_mem[rd_ptr] : '0;
  assign w_last   = w_valid && last_beat;
  assign w_done   = (tx_state == TX_DONE);
  assign tx_busy  = (tx_state != TX_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tx_state <= TX_IDLE;
    else       tx_state <= tx_state_nx;
  end

  // w_valid is driven from the FIFO in PRIME too, so the first beat leaves before the FIFO fills
  always_comb begin
    tx_state_nx = tx_state;
    case (tx_state)
      TX_IDLE:   if (tx_start) tx_state_nx = (tx_len == '0) ? TX_DONE : TX_PRIME;
      TX_PRIME: begin
        if (pop && last_beat)
          tx_state_nx = TX_DONE;
        else if ((fifo_cnt == 2'd2) || ((fifo_cnt != 2'd0) && (len_q == LEN_SIZE'(1))) || pop)
          tx_state_nx = TX_STREAM;
      end
      TX_STREAM: if (pop && last_beat) tx_state_nx = TX_DONE;
      TX_DONE:   tx_state_nx = TX_IDLE;
      default:   tx_state_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q     <= '0;
      base_q    <= '0;
      fetch_cnt <= '0;
      pop_cnt   <= '0;
      inflight  <= 1'b0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      fifo_cnt  <= '0;
      for (int unsigned i = 0; i < 2; i++) fifo_mem[i] <= '0;
    end else begin
      inflight <= fetch;
      if (tx_accept) begin
        len_q     <= tx_len;
        base_q    <= src_base;
        fetch_cnt <= '0;
        pop_cnt   <= '0;
      end else begin
        if (fetch) fetch_cnt <= fetch_cnt + LEN_SIZE'(1);
        if (pop)   pop_cnt   <= pop_cnt + LEN_SIZE'(1);
      end
      if (push) begin
        fifo_mem[wr_ptr] <= src_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // ---------------- RX channel ----------------
  rx_state_t rx_state, rx_state_nx;

  logic [ADDR_SIZE-1:0] dst_base_q;
  logic [LEN_SIZE-1:0]  rx_k;
  logic                 rx_accept, rx_hs, rx_term, done_pend;

  assign r_ready   = (rx_state == RX_ACTIVE);
  assign rx_busy   = (rx_state == RX_ACTIVE);
  assign rx_accept = (rx_state == RX_IDLE) && rx_start;
  assign rx_hs     = r_valid && r_ready;

`ifdef DMA_RX_LEN_CHECK_EN
  logic [LEN_SIZE-1:0] rx_len_q;
  logic                rx_final;

  assign rx_final = (rx_k == rx_len_q - LEN_SIZE'(1));
  assign rx_term  = rx_hs && (r_last || rx_final);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_len_q <= '0;
      rx_err   <= 1'b0;
    end else if (rx_accept) begin
      rx_len_q <= rx_len;
      rx_err   <= 1'b0;
    end else if (rx_hs && (r_last != rx_final)) begin
      rx_err <= 1'b1;
    end
  end
`else
  logic unused_rx_len;

  assign unused_rx_len = ^rx_len;
  assign rx_term       = rx_hs && r_last;
  assign rx_err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rx_state <= RX_IDLE;
    else       rx_state <= rx_state_nx;
  end

  always_comb begin
    rx_state_nx = rx_state;
    case (rx_state)
      RX_IDLE:   if (rx_start) rx_state_nx = RX_ACTIVE;
      RX_ACTIVE: if (rx_term)  rx_state_nx = RX_IDLE;
      default:   rx_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dst_base_q <= '0;
      rx_k       <= '0;
      dst_we     <= 1'b0;
      dst_addr   <= '0;
      dst_data   <= '0;
      done_pend  <= 1'b0;
      rx_done    <= 1'b0;
    end else begin
      if (rx_accept) begin
        dst_base_q <= dst_base;
        rx_k       <= '0;
      end else if (rx_hs) begin
        rx_k <= rx_k + LEN_SIZE'(1);
      end
      dst_we    <= rx_hs;
      dst_addr  <= rx_hs ? dst_base_q + ADDR_SIZE'(rx_k) : '0;
      dst_data  <= rx_hs ? r_data : '0;
      done_pend <= rx_term;
      rx_done   <= done_pend;
    end
  end

endmodule
